// File: rtl/wb_pkg.sv
// Shared types for the execute-stage writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int WB_TAG_W  = 5;
  localparam int WB_DATA_W = 32;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_e;

  // Default-width view of one writeback entry, for neighbouring blocks.
  typedef struct packed {
    logic [WB_TAG_W-1:0]  tag;
    logic [WB_DATA_W-1:0] data;
    wb_src_e              src;
  } wb_entry_t;

endpackage

// File: rtl/wb_arb_pick.sv
// Grant selection between the ALU and load result paths.
// Latency: purely combinational, zero cycles.
// Backpressure: no grant at all unless the writeback entry has space.
module wb_arb_pick (
  input  logic space_i,
  input  logic alu_vld_i,
  input  logic ld_vld_i,
  input  logic pri_ld_i,
  output logic alu_gnt_o,
  output logic ld_gnt_o
);

  // Only valids, space and the tie-break bit are visible here, so data and
  // tags cannot steer arbitration. Load wins a tie when pri_ld_i is set.
  always_comb begin
    alu_gnt_o = 1'b0;
    ld_gnt_o  = 1'b0;
    if (space_i) begin
      ld_gnt_o  = ld_vld_i && (!alu_vld_i || pri_ld_i);
      alu_gnt_o = alu_vld_i && (!ld_vld_i || !pri_ld_i);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares one registered writeback entry between ALU and load results.
// Latency: a result accepted in cycle N is presented on wb_* in cycle N+1.
// Backpressure: readies drop while the entry is held (wb_valid && !wb_ready); WB_ARB_FAIR_EN selects round-robin ties.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_src,
  input  logic              wb_ready,
  output logic [CNT_W-1:0]  wb_count
);

  // Entry layout follows wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    wb_src_e           src;
  } entry_t;

  entry_t           entry_q, entry_d;
  logic             wb_valid_q, wb_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             space;
  logic             pri_ld;
  logic             alu_gnt, ld_gnt;

  assign space = !wb_valid_q || wb_ready;

  wb_arb_pick u_pick (
    .space_i   (space),
    .alu_vld_i (alu_valid),
    .ld_vld_i  (ld_valid),
    .pri_ld_i  (pri_ld),
    .alu_gnt_o (alu_gnt),
    .ld_gnt_o  (ld_gnt)
  );

`ifdef WB_ARB_FAIR_EN
  logic pri_ld_q, pri_ld_d;

  // Round-robin: a granted tie hands priority to the path that lost it.
  always_comb begin
    pri_ld_d = pri_ld_q;
    if (space && alu_valid && ld_valid) pri_ld_d = alu_gnt;
  end

  // Tie-break register; load starts with priority out of reset.
  always_ff @(posedge clk) begin
    if (rst) pri_ld_q <= 1'b1;
    else     pri_ld_q <= pri_ld_d;
  end

  assign pri_ld = pri_ld_q;
`else
  // Fixed priority: load always wins a tie.
  assign pri_ld = 1'b1;
`endif

  // Entry update: load the winner when there is space, otherwise hold.
  // With space and no requester the entry empties but keeps its payload.
  always_comb begin
    entry_d    = entry_q;
    wb_valid_d = wb_valid_q;
    count_d    = count_q;
    if (wb_valid_q && wb_ready) count_d = count_q + CNT_W'(1);
    if (space) begin
      wb_valid_d = alu_gnt || ld_gnt;
      if (ld_gnt) begin
        entry_d = '{tag: ld_tag, data: ld_data, src: WB_SRC_LD};
      end else if (alu_gnt) begin
        entry_d = '{tag: alu_tag, data: alu_data, src: WB_SRC_ALU};
      end
    end
  end

  // Output entry and writeback counter; reset discards any entry in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q    <= '0;
      wb_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      entry_q    <= entry_d;
      wb_valid_q <= wb_valid_d;
      count_q    <= count_d;
    end
  end

  // Nothing is accepted while reset is asserted.
  assign alu_ready = alu_gnt && !rst;
  assign ld_ready  = ld_gnt && !rst;

  assign wb_valid = wb_valid_q;
  assign wb_tag   = entry_q.tag;
  assign wb_data  = entry_q.data;
  assign wb_src   = entry_q.src;
  assign wb_count = count_q;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the execute stage: shares the single register-file writeback port between the ALU result path and the load-result path. Holds one registered writeback entry and applies valid/ready handshakes on both sides. Arbitration depends only on valid/ready/priority state, never on data or tag values, so data cannot influence which path is granted. Sits between the execute/load units and the writeback register (`wb_*`).

## Interface
- `DATA_W`, 32, width of result data
- `TAG_W`, 5, destination-register tag width
- `CNT_W`, 16, width of the writeback event counter

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `alu_valid` in 1 — ALU result offered
- `alu_tag` in TAG_W — ALU destination tag
- `alu_data` in DATA_W — ALU result
- `alu_ready` out 1 — ALU result accepted this cycle when high with `alu_valid`
- `ld_valid` in 1 — load result offered
- `ld_tag` in TAG_W — load destination tag
- `ld_data` in DATA_W — load result
- `ld_ready` out 1 — load result accepted this cycle when high with `ld_valid`
- `wb_valid` out 1 — writeback entry valid
- `wb_tag` out TAG_W — writeback tag
- `wb_data` out DATA_W — writeback data
- `wb_src` out 1 — 0 = ALU, 1 = load
- `wb_ready` in 1 — consumer accepts the entry
- `wb_count` out CNT_W — completed writebacks (`wb_valid && wb_ready`)

## Operation
- One output register (entry). `space = !wb_valid || wb_ready`.
- Grant computed only when `space`; at most one of `alu_ready`/`ld_ready` high per cycle; both low when `!space`.
- Only one valid requester: it is granted.
- Both valid: winner selected by the priority policy (see Configuration).
- On grant: entry loads the winner's tag/data, `wb_src` set, `wb_valid` = 1.
- `space` and no requester valid: `wb_valid` → 0; tag/data/src hold their previous values.
- Entry held unchanged while `wb_valid && !wb_ready`, with no grant; requesters must keep their offers stable (upstream rule, not checked).
- `wb_count` increments on each `wb_valid && wb_ready` and wraps modulo 2^CNT_W.
- Priority state `pri_ld` (1 bit): 1 means load wins the next tie.
- Ready outputs are combinational from `*_valid`, `wb_valid`, `wb_ready`, `pri_ld`; no path from any data or tag input to any ready, `wb_valid`, or `wb_src`.

## Timing
- Latency: input accepted in cycle N appears on `wb_*` in cycle N+1.
- Throughput: one writeback per cycle with `wb_ready` held high.
- Reset (synchronous): `wb_valid`=0, `wb_tag`=0, `wb_data`=0, `wb_src`=0, `wb_count`=0, `pri_ld`=1. Readies are low during the reset cycle. An entry in flight is discarded.
- Accept and drain in the same cycle are allowed: the old entry leaves and the new entry loads.
- `pri_ld` updates only on a cycle in which a tie is granted.

## Configuration
- `WB_ARB_FAIR_EN` defined: round-robin on ties. After a tie is granted to load, `pri_ld` ← 0; after a tie is granted to ALU, `pri_ld` ← 1. Starvation is bounded to one lost tie.
- Not defined: fixed priority, load always wins ties. `pri_ld` is tied to 1 and carries no flop.

## Structure
- Package `wb_pkg`: `wb_src_e` enum (`WB_SRC_ALU`=0, `WB_SRC_LD`=1), and a packed `wb_entry_t` struct {tag, data, src}.
- Sub-module `wb_arb_pick`: pure combinational grant logic. Inputs are the two valids, `space`, and `pri_ld`; outputs are the two grants. Isolating it makes it straightforward to show that grant logic has no data dependence.

## Test plan
- Reset, then `alu_valid`=1, tag 3, data 0x11, `wb_ready`=1 → cycle+1: `wb_valid`=1, `wb_tag`=3, `wb_data`=0x11, `wb_src`=0; `wb_count`=1 the following cycle.
- Tie after reset (ALU tag 1/0xA, load tag 2/0xB), both held for 2 cycles, `wb_ready`=1 → outputs: load 0xB, then ALU 0xA (FAIR_EN). Without FAIR_EN: load, then load again while load is offered.
- `wb_ready`=0 for 3 cycles with a valid entry 0x55 → entry stable, both readies 0, `wb_count` unchanged. Raising `wb_ready` drains 0x55, and the pending request loads in the same cycle.
- Back-to-back ALU stream 0x1..0x8, `wb_ready`=1 → eight consecutive writebacks, `wb_count`=8.
- Assert `rst` while `wb_valid`=1 and `wb_ready`=0 → next cycle: `wb_valid`=0, `wb_count`=0, entry dropped.
- Two runs with identical valid/ready patterns but different `alu_data`/`ld_data` → identical `alu_ready`, `ld_ready`, `wb_valid`, `wb_src` traces.
